// File: rtl/traffic_pkg.sv
// Shared types and way/one-hot helpers for the traffic light controller and its scheduler.
// Way w maps to vector bit (3-w), so approach A is always the MSB.
package traffic_pkg;

    typedef enum logic [1:0] {
        WAY_A = 2'd0,
        WAY_B = 2'd1,
        WAY_C = 2'd2,
        WAY_D = 2'd3
    } way_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } sched_state_t;

    function automatic logic [3:0] way2onehot(way_t w);
        return 4'b1000 >> w;
    endfunction

    // Only meaningful for a one-hot input; anything else falls through to WAY_D.
    function automatic way_t onehot2way(logic [3:0] oh);
        case (oh)
            4'b1000: return WAY_A;
            4'b0100: return WAY_B;
            4'b0010: return WAY_C;
            default: return WAY_D;
        endcase
    endfunction

endpackage

// File: rtl/traffic_rr_picker.sv
// Combinational round-robin picker: first requesting way after ptr, wrapping A>B>C>D>A.
module traffic_rr_picker
    import traffic_pkg::*;
(
    input  logic [3:0] req,
    input  way_t       ptr,
    output logic       valid,
    output way_t       way
);

    logic [1:0] cand;

    // Walk from the farthest candidate (ptr+4) to the nearest (ptr+1) so the nearest wins.
    always_comb begin
        valid = 1'b0;
        way   = WAY_A;
        cand  = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + k[1:0];
            if (req[~cand]) begin
                valid = 1'b1;
                way   = way_t'(cand);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Fair round-robin front end for the 4-way light controller with emergency preemption;
// drives a one-hot switch request and waits for light_en to confirm it.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter logic [7:0] ACK_TIMEOUT = 8'd64,
    parameter logic [7:0] HOLD_CYCLES = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] car_req,
    input  logic       emerg_req,
    input  logic [1:0] emerg_way,
    input  logic [3:0] light_en,
    output logic [3:0] switch_to,
    output logic [3:0] pending,
    output logic [1:0] grant_way,
    output logic       busy,
    output logic       emerg_active,
    output logic       ack_timeout
);

    sched_state_t state, state_n;
    way_t         target, target_n, rr_ptr, rr_ptr_n, pick_way, green_way, emerg_tgt;
    logic [7:0]   wait_cnt, wait_cnt_n;
    logic [3:0]   switch_to_n, pending_n, green_mask;
    logic [1:0]   grant_way_n;
    logic         emerg_active_n, ack_timeout_n, pick_vld, green_vld, emerg_green, confirm;

    // A light_en that is not one-hot means no approach is green.
    assign green_vld   = $onehot(light_en);
    assign green_way   = onehot2way(light_en);
    assign green_mask  = green_vld ? light_en : 4'b0000;
    assign emerg_tgt   = way_t'(emerg_way);
    assign emerg_green = green_vld && (green_way == emerg_tgt);
    assign confirm     = green_vld && (green_way == target);
    assign pending_n   = (pending | car_req) & ~green_mask;
    assign busy        = (state != S_IDLE);

    traffic_rr_picker u_picker (
        .req   (pending & ~green_mask),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .way   (pick_way)
    );

    always_comb begin
        state_n        = state;
        target_n       = target;
        wait_cnt_n     = wait_cnt;
        rr_ptr_n       = rr_ptr;
        switch_to_n    = switch_to;
        grant_way_n    = grant_way;
        emerg_active_n = emerg_active;
        ack_timeout_n  = 1'b0;
        case (state)
            S_IDLE: begin
                switch_to_n    = 4'b0000;
                emerg_active_n = 1'b0;
                wait_cnt_n     = 8'd0;
                if (emerg_req && emerg_green) begin
                    emerg_active_n = 1'b1;
                end else if (emerg_req) begin
                    target_n       = emerg_tgt;
                    emerg_active_n = 1'b1;
                    switch_to_n    = way2onehot(emerg_tgt);
                    state_n        = S_WAIT;
                end else if (pick_vld) begin
                    target_n    = pick_way;
                    switch_to_n = way2onehot(pick_way);
                    state_n     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (confirm) begin
                    grant_way_n    = target;
                    rr_ptr_n       = target;
                    emerg_active_n = emerg_req && (emerg_tgt == target);
                    switch_to_n    = 4'b0000;
                    wait_cnt_n     = 8'd0;
                    state_n        = (HOLD_CYCLES == 8'd0) ? S_IDLE : S_HOLD;
                end else if (emerg_req && (emerg_tgt != target)) begin
                    emerg_active_n = 1'b1;
                    wait_cnt_n     = 8'd0;
                    if (emerg_green) begin
                        // Emergency way is already green: drop the request rather than switch away.
                        switch_to_n = 4'b0000;
                        state_n     = S_IDLE;
                    end else begin
                        target_n    = emerg_tgt;
                        switch_to_n = way2onehot(emerg_tgt);
                    end
                end else if (wait_cnt == ACK_TIMEOUT - 8'd1) begin
                    // Abandon: moving rr_ptr onto the target makes the next pick skip past it.
                    ack_timeout_n  = 1'b1;
                    switch_to_n    = 4'b0000;
                    rr_ptr_n       = target;
                    emerg_active_n = 1'b0;
                    wait_cnt_n     = 8'd0;
                    state_n        = S_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                switch_to_n = 4'b0000;
                if (!emerg_req) emerg_active_n = 1'b0;
                if (emerg_req && !emerg_green) begin
                    target_n       = emerg_tgt;
                    emerg_active_n = 1'b1;
                    switch_to_n    = way2onehot(emerg_tgt);
                    wait_cnt_n     = 8'd0;
                    state_n        = S_WAIT;
                end else if (wait_cnt == HOLD_CYCLES - 8'd1) begin
                    wait_cnt_n = 8'd0;
                    state_n    = S_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            default: begin
                switch_to_n = 4'b0000;
                wait_cnt_n  = 8'd0;
                state_n     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            target       <= WAY_A;
            rr_ptr       <= WAY_A;
            wait_cnt     <= 8'd0;
            switch_to    <= 4'b0000;
            pending      <= 4'b0000;
            grant_way    <= 2'd0;
            emerg_active <= 1'b0;
            ack_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            rr_ptr       <= rr_ptr_n;
            wait_cnt     <= wait_cnt_n;
            switch_to    <= switch_to_n;
            pending      <= pending_n;
            grant_way    <= grant_way_n;
            emerg_active <= emerg_active_n;
            ack_timeout  <= ack_timeout_n;
        end
    end

endmodule
